wb_arbiter: RTL and testbench

Write-back arbiter and load scoreboard for the 64-bit core's register file. It shares the file's single write port between the single-cycle ALU result path and the variable-latency load-return path. The ALU always wins the port; load returns wait in a small FIFO. It also tracks registers with an outstanding load so decode can detect RAW hazards. It sits between the execute/memory stages and the register file, and drives the file's RegWrite / Write_register / Write_d inputs directly.

---
 rtl/wb_arbiter.sv | 142 ++++++++++++++
 tb/tb_wb_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_arbiter: register-file write-port arbiter (ALU first, load FIFO next) |
// | with a load scoreboard for decode RAW-hazard queries.   Revision: 1.0    |
// +--------------------------------------------------------------------------+
module wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [63:0] alu_data,
  input  logic        alu_sp,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [63:0] ld_data,
  input  logic        ld_sp,
  input  logic        sb_set,
  input  logic [4:0]  sb_rd,
  input  logic [4:0]  q_rd1,
  input  logic [4:0]  q_rd2,
  output logic        q_busy1,
  output logic        q_busy2,
  output logic        RegWrite,
  output logic [4:0]  Write_register,
  output logic [63:0] Write_d
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [4:0]    ZR_REG     = 5'd31;

  logic [4:0]    fifo_rd   [DEPTH];
  logic [63:0]   fifo_data [DEPTH];
  logic          fifo_sp   [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic [31:0]   pending;
  logic [31:0]   pending_next;
  logic          from_ld;

  logic          push;
  logic          pop;
  logic          sel_valid;
  logic [4:0]    sel_rd;
  logic [63:0]   sel_data;
  logic          sel_sp;
  logic          sel_commit;

  // Ready comes from the registered count only, so a pop in a full cycle
  // cannot make room for a same-cycle push.
  assign ld_ready = ~reset & (count != FULL_COUNT);
  assign push     = ld_valid & ld_ready;
  assign pop      = ~alu_valid & (count != '0);

  always_comb begin
    sel_valid = alu_valid | pop;
    sel_rd    = fifo_rd[head];
    sel_data  = fifo_data[head];
    sel_sp    = fifo_sp[head];
    if (alu_valid) begin
      sel_rd   = alu_rd;
      sel_data = alu_data;
      sel_sp   = alu_sp;
    end
    // rd=31 without SP is XZR: the slot is used but nothing is written.
    sel_commit = sel_valid & ~((sel_rd == ZR_REG) & ~sel_sp);
  end

  // Set beats clear when both target the same register in one cycle.
  always_comb begin
    pending_next = pending;
    if (pop) begin
      pending_next[fifo_rd[head]] = 1'b0;
    end
    if (sb_set) begin
      pending_next[sb_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[tail]   <= ld_rd;
      fifo_data[tail] <= ld_data;
      fifo_sp[tail]   <= ld_sp;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegWrite       <= 1'b0;
      Write_register <= '0;
      Write_d        <= '0;
      from_ld        <= 1'b0;
    end else begin
      RegWrite <= sel_commit;
      from_ld  <= pop;
      if (sel_valid) begin
        Write_register <= sel_rd;
        Write_d        <= sel_data;
      end
    end
  end

  // A load sitting in the output register is still uncommitted to the file.
  assign q_busy1 = pending[q_rd1] | (RegWrite & from_ld & (Write_register == q_rd1));
  assign q_busy2 = pending[q_rd2] | (RegWrite & from_ld & (Write_register == q_rd2));

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// Self-checking bench for wb_arbiter: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_wb_arbiter;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_sp, ld_valid, ld_sp, sb_set;
  logic [4:0]  alu_rd, ld_rd, sb_rd, q_rd1, q_rd2;
  logic [63:0] alu_data, ld_data;
  logic        ld_ready, q_busy1, q_busy2, RegWrite;
  logic [4:0]  Write_register;
  logic [63:0] Write_d;

  int checks = 0;
  int errors = 0;

  wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_sp(alu_sp),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data), .ld_sp(ld_sp),
    .sb_set(sb_set), .sb_rd(sb_rd), .q_rd1(q_rd1), .q_rd2(q_rd2),
    .q_busy1(q_busy1), .q_busy2(q_busy2),
    .RegWrite(RegWrite), .Write_register(Write_register), .Write_d(Write_d)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        av;
    logic [4:0]  rd;
    logic [63:0] data;
    logic        sp;
    logic        exp_rw;
    logic [4:0]  exp_wr;
    logic [63:0] exp_wd;
  } alu_vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    logic        sp;
  } ent_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0; alu_sp = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0; ld_sp = 0;
    sb_set = 0; sb_rd = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
    #1;
  endtask

  alu_vec_t vecs[6];

  // Reference model state
  ent_t        mq[$];
  bit   [31:0] m_pend;
  bit          m_rw, m_from;
  logic [4:0]  m_wr;
  logic [63:0] m_wd;

  initial begin
    vecs[0] = '{1'b1, 5'd5,  64'hDEAD_BEEF,          1'b0, 1'b1, 5'd5,  64'hDEAD_BEEF};
    vecs[1] = '{1'b0, 5'd3,  64'h1111,               1'b0, 1'b0, 5'd0,  64'h0};
    vecs[2] = '{1'b1, 5'd31, 64'h8000,               1'b1, 1'b1, 5'd31, 64'h8000};
    vecs[3] = '{1'b1, 5'd31, 64'h55,                 1'b0, 1'b0, 5'd0,  64'h0};
    vecs[4] = '{1'b1, 5'd0,  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 5'd0,  64'hFFFF_FFFF_FFFF_FFFF};
    vecs[5] = '{1'b1, 5'd17, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b1, 5'd17, 64'h0123_4567_89AB_CDEF};

    q_rd1 = 0; q_rd2 = 0;
    idle_inputs();
    reset = 1;
    #3;
    check("reset_regwrite", RegWrite, 0);
    check("reset_wreg", Write_register, 0);
    check("reset_wd", Write_d, 0);
    check("reset_ld_ready", ld_ready, 0);
    check("reset_busy1", q_busy1, 0);
    tick();
    reset = 0;
    #1;
    check("post_reset_ld_ready", ld_ready, 1);

    // ALU vector table
    foreach (vecs[i]) begin
      alu_valid = vecs[i].av; alu_rd = vecs[i].rd; alu_data = vecs[i].data; alu_sp = vecs[i].sp;
      tick();
      idle_inputs();
      check($sformatf("vec%0d_regwrite", i), RegWrite, vecs[i].exp_rw);
      if (vecs[i].exp_rw) begin
        check($sformatf("vec%0d_wreg", i), Write_register, vecs[i].exp_wr);
        check($sformatf("vec%0d_wd", i), Write_d, vecs[i].exp_wd);
      end
      tick();
      check($sformatf("vec%0d_idle_regwrite", i), RegWrite, 0);
    end

    // Load path with scoreboard
    q_rd1 = 7;
    sb_set = 1; sb_rd = 7;
    tick();
    sb_set = 0;
    #1;
    check("ld_busy_c1", q_busy1, 1);
    tick();
    tick();
    ld_valid = 1; ld_rd = 7; ld_data = 64'h1234; ld_sp = 0;
    #1;
    check("ld_ready_c3", ld_ready, 1);
    tick();
    ld_valid = 0;
    #1;
    check("ld_c4_regwrite", RegWrite, 0);
    check("ld_c4_busy", q_busy1, 1);
    tick();
    check("ld_c5_regwrite", RegWrite, 1);
    check("ld_c5_wreg", Write_register, 7);
    check("ld_c5_wd", Write_d, 64'h1234);
    check("ld_c5_busy", q_busy1, 1);
    tick();
    check("ld_c6_busy", q_busy1, 0);
    check("ld_c6_regwrite", RegWrite, 0);

    // Contention and full FIFO
    alu_valid = 1; alu_rd = 10; alu_data = 64'hA0;
    ld_valid = 1; ld_rd = 2; ld_data = 64'h222;
    #1;
    check("full_ready0", ld_ready, 1);
    tick();
    check("full_alu0", Write_register, 10);
    alu_data = 64'hA1; ld_rd = 3; ld_data = 64'h333;
    #1;
    check("full_ready1", ld_ready, 1);
    tick();
    alu_data = 64'hA2; ld_rd = 4; ld_data = 64'h444;
    #1;
    check("full_ready2", ld_ready, 0);
    tick();
    check("full_alu2_rw", RegWrite, 1);
    check("full_alu2_wd", Write_d, 64'hA2);
    ld_valid = 0; alu_valid = 0;
    #1;
    check("full_ready3", ld_ready, 0);
    tick();
    check("drain1_rw", RegWrite, 1);
    check("drain1_wreg", Write_register, 2);
    check("drain1_wd", Write_d, 64'h222);
    check("drain1_ready", ld_ready, 1);
    tick();
    check("drain2_wreg", Write_register, 3);
    check("drain2_wd", Write_d, 64'h333);
    tick();
    check("drain3_rw", RegWrite, 0);

    // XZR load discard clears pending[31]
    q_rd1 = 31;
    sb_set = 1; sb_rd = 31;
    tick();
    sb_set = 0;
    ld_valid = 1; ld_rd = 31; ld_sp = 0; ld_data = 64'h99;
    #1;
    check("xzr_busy_set", q_busy1, 1);
    tick();
    ld_valid = 0;
    tick();
    check("xzr_rw", RegWrite, 0);
    check("xzr_busy_clr", q_busy1, 0);

    // Same-cycle set and clear
    q_rd2 = 9;
    sb_set = 1; sb_rd = 9;
    tick();
    sb_set = 0;
    ld_valid = 1; ld_rd = 9; ld_data = 64'h909;
    tick();
    ld_valid = 0;
    sb_set = 1; sb_rd = 9;
    tick();
    sb_set = 0;
    check("setclr_rw", RegWrite, 1);
    check("setclr_wreg", Write_register, 9);
    tick();
    check("setclr_busy_after", q_busy2, 1);

    // Reset mid-operation
    do_reset();
    q_rd1 = 12; q_rd2 = 13;
    alu_valid = 1; alu_rd = 20; alu_data = 64'h77;
    sb_set = 1; sb_rd = 12;
    ld_valid = 1; ld_rd = 12; ld_data = 64'hC0;
    tick();
    sb_rd = 13; ld_rd = 13; ld_data = 64'hD0;
    tick();
    idle_inputs();
    alu_valid = 1; alu_rd = 21; alu_data = 64'h78;
    #1;
    check("midrst_pre_rw", RegWrite, 1);
    check("midrst_pre_busy", q_busy1, 1);
    reset = 1;
    #1;
    check("midrst_rw", RegWrite, 0);
    check("midrst_busy1", q_busy1, 0);
    check("midrst_busy2", q_busy2, 0);
    check("midrst_ready", ld_ready, 0);
    idle_inputs();
    tick();
    reset = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("midrst_stale%0d", k), RegWrite, 0);
    end

    // Randomized traffic against the reference model
    do_reset();
    mq.delete();
    m_pend = '0; m_rw = 0; m_from = 0; m_wr = 0; m_wd = 0;
    for (int n = 0; n < 400; n++) begin
      bit          m_ready, sel, fromq;
      logic [4:0]  srd;
      logic        ssp;
      logic [63:0] sd;
      ent_t        e;
      alu_valid = ($urandom_range(0, 9) < 5);
      alu_rd    = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      alu_data  = {$urandom, $urandom};
      alu_sp    = 1'($urandom);
      ld_valid  = 1'($urandom);
      ld_rd     = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      ld_data   = {$urandom, $urandom};
      ld_sp     = 1'($urandom);
      sb_set    = ($urandom_range(0, 3) == 0);
      sb_rd     = 5'($urandom_range(0, 31));
      q_rd1     = 5'($urandom_range(0, 31));
      q_rd2     = 5'($urandom_range(0, 31));
      #1;
      m_ready = (mq.size() != DEPTH);
      check("rnd_ready", ld_ready, m_ready);
      check("rnd_busy1", q_busy1, m_pend[q_rd1] | (m_rw & m_from & (m_wr == q_rd1)));
      check("rnd_busy2", q_busy2, m_pend[q_rd2] | (m_rw & m_from & (m_wr == q_rd2)));
      sel = 0; fromq = 0; srd = 0; ssp = 0; sd = 0;
      if (alu_valid) begin
        sel = 1; srd = alu_rd; ssp = alu_sp; sd = alu_data;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        sel = 1; fromq = 1; srd = e.rd; ssp = e.sp; sd = e.data;
        m_pend[e.rd] = 1'b0;
      end
      if (ld_valid && m_ready) mq.push_back('{ld_rd, ld_data, ld_sp});
      if (sb_set) m_pend[sb_rd] = 1'b1;
      if (sel) begin
        m_rw = !(srd == 5'd31 && !ssp);
        m_wr = srd; m_wd = sd; m_from = fromq;
      end else begin
        m_rw = 0;
      end
      tick();
      check("rnd_regwrite", RegWrite, m_rw);
      if (m_rw) begin
        check("rnd_wreg", Write_register, m_wr);
        check("rnd_wd", Write_d, m_wd);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
